regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// - Parametrised multi-port GPR file; successor to the 2R/1W regfile. Sits in ID (reads) and WB (writes).
// - Adds N write ports, N read ports with write-through bypass, hardware clear sequencer, per-register busy scoreboard.
// - Scoreboard lets ID detect pending producers, e.g. load-use, without a separate hazard table.
// PARAMETERS
// - DATA_W  32  register width in bits
// - NREG    32  number of registers, power of 2, >=2; AW = $clog2(NREG)
// - NRD      2  read ports
// - NWR      2  write ports; higher port index has higher priority
// - ZERO_R0  1  1: r0 reads 0, ignores writes and sb_set; 0: r0 is an ordinary register
// PORTS
// - clk        in   1           clock; all state updates on posedge
// - rst        in   1           reset, synchronous, active-low (0 = reset)
// - we         in   NWR         per-port write enable
// - waddr      in   NWR*AW      write addresses; port k = [k*AW +: AW]
// - wdata      in   NWR*DATA_W  write data; port k = [k*DATA_W +: DATA_W]
// - re         in   NRD         per-port read enable
// - raddr      in   NRD*AW      read addresses
// - rdata      out  NRD*DATA_W  read data, combinational
// - rd_busy    out  NRD         1 = register on read port i has a pending producer
// - sb_set     in   1           mark sb_addr busy: producer issued
// - sb_addr    in   AW          register marked by sb_set
// - init_done  out  1           1 = clear sequence finished; file usable
// BEHAVIOUR
// - FSM states: INIT, RUN. When rst==0 at a posedge: state<=INIT, clr_cnt<=0, all busy bits<=0.
// - INIT: each cycle regs[clr_cnt]<=0 and clr_cnt++. After writing NREG-1, next state is RUN.
//   - Clear takes exactly NREG cycles after rst is released.
//   - we and sb_set are ignored in INIT.
//   - rdata=0, rd_busy=0, init_done=0.
// - RUN: init_done=1.
// - Reset asserted mid-INIT or in RUN restarts INIT from clr_cnt=0. Register contents are undefined until INIT completes.
// - Write: regs[waddr[k]]<=wdata[k] when we[k], state RUN, and not (ZERO_R0 && waddr[k]==0).
//   - Same address on two ports in one cycle: highest k wins.
//   - Different addresses on ports: all writes commit.
// - Read port i, combinational, evaluated in priority order:
//   1. state!=RUN or re[i]==0: rdata=0.
//   2. ZERO_R0 && raddr==0: rdata=0.
//   3. Any enabled write port to raddr this cycle: rdata=wdata of the highest such k (bypass).
//   4. Otherwise: rdata=regs[raddr].
// - Scoreboard (RUN only): busy[a] cleared at posedge by any enabled, legal write to a.
//   - busy[a] set by sb_set with sb_addr==a. sb_set ignored for r0 when ZERO_R0.
//   - Set and clear on the same address in the same cycle: set wins, because a new producer was issued.
// - rd_busy[i] = re[i] && busy[raddr[i]] && no enabled write to raddr[i] this cycle (the bypass covers it).
//   - rd_busy[i] is 0 for r0 when ZERO_R0.
// - No output is registered; rdata, rd_busy and init_done are combinational from current state and inputs.
// TESTING
// - Reset for 2 cycles, then release: init_done=0 for exactly 32 cycles, then 1.
//   - Reads of r1..r31 return 0. Writes attempted during INIT do not land.
// - RUN, we=2'b01, waddr0=5, wdata0=0xDEADBEEF, re0=1, raddr0=5: rdata0=0xDEADBEEF in the same cycle.
//   - Next cycle, with no writes: rdata0=0xDEADBEEF.
// - we=2'b11, waddr0=waddr1=7, wdata0=0x1111, wdata1=0x2222: bypass gives 0x2222; regs[7]=0x2222 afterwards.
// - Write r0=0xFFFF_FFFF with ZERO_R0=1: read r0 returns 0. Issue sb_set addr 0: rd_busy for r0 stays 0.
// - sb_set addr 9: next cycle rd_busy=1 on raddr=9.
//   - Write r9 with sb_set addr 9 in the same cycle: busy stays 1.
//   - A later write to r9 alone: rd_busy=0 during that write cycle, still 0 after it.
// - Assert rst mid-INIT at clr_cnt=12, and again in RUN with busy[3]=1: INIT restarts and lasts 32 cycles; busy[3]=0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file with write-through bypass, clear sequencer and busy scoreboard
// Reads are combinational; writes, clear sequence and scoreboard update on posedge clk.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr,
    output logic                  init_done
);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [AW-1:0]       clr_cnt;
    logic [DATA_W-1:0]   regs [NREG];
    logic [NREG-1:0]     busy;

    logic [AW-1:0]       ra;
    logic                hit;
    logic [DATA_W-1:0]   val;

    function automatic logic is_r0(input logic [AW-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= INIT;
            clr_cnt <= '0;
            busy    <= '0;
        end else begin
            case (state)
                INIT: begin
                    regs[clr_cnt] <= '0;
                    clr_cnt       <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(NREG - 1))
                        state <= RUN;
                end
                RUN: begin
                    // Ascending port order lets the highest port win on an address clash.
                    for (int k = 0; k < NWR; k++) begin
                        if (we[k] && !is_r0(waddr[k*AW +: AW])) begin
                            regs[waddr[k*AW +: AW]] <= wdata[k*DATA_W +: DATA_W];
                            busy[waddr[k*AW +: AW]] <= 1'b0;
                        end
                    end
                    // Issued after the clears so a new producer overrides a retiring one.
                    if (sb_set && !is_r0(sb_addr))
                        busy[sb_addr] <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign init_done = (state == RUN);

    always_comb begin
        rdata   = '0;
        rd_busy = '0;
        ra      = '0;
        hit     = 1'b0;
        val     = '0;
        for (int i = 0; i < NRD; i++) begin
            ra  = raddr[i*AW +: AW];
            hit = 1'b0;
            val = regs[ra];
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (waddr[k*AW +: AW] == ra)) begin
                    hit = 1'b1;
                    val = wdata[k*DATA_W +: DATA_W];
                end
            end
            if ((state == RUN) && re[i] && !is_r0(ra)) begin
                rdata[i*DATA_W +: DATA_W] = val;
                rd_busy[i]                = busy[ra] && !hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized scoreboard bench for regfile_mp
// Driver pushes expected outputs from a register-array model; monitor pops and compares on negedge.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int WAW = NWR * AW;
    localparam int RAW = NRD * AW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NWR-1:0]     we;
    logic [WAW-1:0]     waddr;
    logic [NWR*DW-1:0]  wdata;
    logic [NRD-1:0]     re;
    logic [RAW-1:0]     raddr;
    logic [NRD*DW-1:0]  rdata;
    logic [NRD-1:0]     rd_busy;
    logic               sb_set;
    logic [AW-1:0]      sb_addr;
    logic               init_done;

    regfile_mp #(.DATA_W(DW), .NREG(NR), .NRD(NRD), .NWR(NWR), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
        .sb_set(sb_set), .sb_addr(sb_addr), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                tag;
        logic              done;
        logic [NRD*DW-1:0] rd;
        logic [NRD-1:0]    bz;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   tag   = 0;

    // Model: architectural register contents, pending-producer flags, cycles of clearing done.
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    int            m_cnt = 0;

    task automatic step(input bit chk);
        exp_t          e;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        bit            hit;
        e.tag  = tag;
        e.done = (m_cnt == NR);
        e.rd   = '0;
        e.bz   = '0;
        for (int i = 0; i < NRD; i++) begin
            a = raddr[i*AW +: AW];
            if (e.done && re[i] && a != 0) begin
                hit = 0;
                v   = m_regs[a];
                for (int k = 0; k < NWR; k++)
                    if (we[k] && waddr[k*AW +: AW] == a) begin
                        hit = 1;
                        v   = wdata[k*DW +: DW];
                    end
                e.rd[i*DW +: DW] = v;
                e.bz[i]          = m_busy[a] && !hit;
            end
        end
        if (chk) sbq.push_back(e);
        tag++;
        @(posedge clk);
        if (!rst) begin
            m_cnt = 0;
            for (int r = 0; r < NR; r++) m_busy[r] = 0;
        end else if (m_cnt < NR) begin
            m_cnt++;
            if (m_cnt == NR)
                for (int r = 0; r < NR; r++) m_regs[r] = '0;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (we[k] && waddr[k*AW +: AW] != 0) begin
                    m_regs[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
                    m_busy[waddr[k*AW +: AW]] = 0;
                end
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1;
        end
        #1;
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0; sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic rnd();
        we      = NWR'($urandom);
        waddr   = WAW'($urandom);
        wdata   = {$urandom, $urandom};
        re      = NRD'($urandom);
        raddr   = RAW'($urandom);
        sb_set  = ($urandom_range(0, 3) == 0);
        sb_addr = AW'($urandom);
    endtask

    task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        re = 2'b11;
        raddr = {a1, a0};
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if (init_done !== e.done) begin
                fails++;
                $display("FAIL init_done tag=%0d got=%b exp=%b", e.tag, init_done, e.done);
            end
            for (int i = 0; i < NRD; i++) begin
                tests++;
                if (rdata[i*DW +: DW] !== e.rd[i*DW +: DW]) begin
                    fails++;
                    $display("FAIL rdata%0d tag=%0d got=%h exp=%h", i, e.tag,
                             rdata[i*DW +: DW], e.rd[i*DW +: DW]);
                end
                tests++;
                if (rd_busy[i] !== e.bz[i]) begin
                    fails++;
                    $display("FAIL rd_busy%0d tag=%0d got=%b exp=%b", i, e.tag, rd_busy[i], e.bz[i]);
                end
            end
        end
    end

    initial begin
        for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
        idle();
        rst = 1'b0;
        step(0);
        step(0);
        rst = 1'b1;
        // Clear sequence with hostile writes and scoreboard sets.
        for (int c = 0; c < NR; c++) begin
            rnd();
            we = 2'b11;
            sb_set = 1'b1;
            step(1);
        end
        idle();
        for (int a = 1; a < NR; a += 2) begin rd2(AW'(a), AW'(a + 1)); step(1); end

        // Same-cycle bypass, then stored value.
        idle(); we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF}; rd2(5, 5); step(1);
        idle(); rd2(5, 0); step(1);
        // Same-address clash: port 1 wins.
        idle(); we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h2222, 32'h1111}; rd2(7, 7); step(1);
        idle(); rd2(7, 5); step(1);
        // r0 hardwired.
        idle(); we = 2'b01; waddr = '0; wdata = {32'h0, 32'hFFFF_FFFF}; rd2(0, 0); step(1);
        idle(); sb_set = 1'b1; sb_addr = 0; rd2(0, 0); step(1);
        idle(); rd2(0, 0); step(1);
        // Scoreboard set, set-beats-clear, then clear on a lone write.
        idle(); sb_set = 1'b1; sb_addr = 9; step(1);
        idle(); rd2(9, 9); step(1);
        idle(); we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99}; sb_set = 1'b1; sb_addr = 9; step(1);
        idle(); rd2(9, 9); step(1);
        idle(); we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'hABCD, 32'h0}; rd2(9, 9); step(1);
        idle(); rd2(9, 9); step(1);

        for (int c = 0; c < 300; c++) begin rnd(); step(1); end

        // Reset mid-clear at clr_cnt=12.
        idle(); rst = 1'b0; step(1);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin rd2(AW'(c), 3); step(1); end
        rst = 1'b0; step(1);
        rst = 1'b1;
        for (int c = 0; c < NR; c++) begin rnd(); step(1); end
        // Reset in RUN with r3 busy.
        idle(); sb_set = 1'b1; sb_addr = 3; step(1);
        idle(); rd2(3, 3); step(1);
        rst = 1'b0; step(1);
        rst = 1'b1;
        for (int c = 0; c < NR; c++) begin rd2(3, AW'(c)); step(1); end
        idle(); rd2(3, 3); step(1);
        for (int c = 0; c < 100; c++) begin rnd(); step(1); end

        idle();
        step(0);
        step(0);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d exp=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
